// File: rtl/spi_slave_mlf_pkg.sv
// Shared SPI definitions: byte width, mode decode and slave state encoding.
package spi_mlf_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } slv_state_e;

  // Clock polarity: the idle level of SCLK.
  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Clock phase: 0 samples on the leading edge, 1 on the trailing edge.
  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_mlf_if.sv
// User byte handshake plus SPI pins of the slave, bundled for port lists.
interface spi_slave_mlf_if;
  import spi_mlf_pkg::*;

  logic [SPI_BYTE_W-1:0] i_TX_Byte;
  logic                  i_TX_DV;
  logic                  o_TX_Ready;
  logic                  o_RX_DV;
  logic [SPI_BYTE_W-1:0] o_RX_Byte;
  logic                  i_SPI_clk;
  logic                  i_SPI_CS_n;
  logic                  i_SPI_MOSI;
  logic                  o_SPI_MISO;
  logic                  o_SPI_MISO_En;

  modport slave (
    input  i_TX_Byte, i_TX_DV, i_SPI_clk, i_SPI_CS_n, i_SPI_MOSI,
    output o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_MISO, o_SPI_MISO_En
  );

  modport master (
    output i_TX_Byte, i_TX_DV, i_SPI_clk, i_SPI_CS_n, i_SPI_MOSI,
    input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_MISO, o_SPI_MISO_En
  );

endinterface

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser with a third stage for rise/fall detection.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] sr_q;

  // Reset to the idle level of the line so release of reset is not an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sr_q <= {3{RST_VAL}};
    else          sr_q <= {sr_q[1:0], i_async};
  end

  assign o_sync = sr_q[1];
  assign o_rise =  sr_q[1] & ~sr_q[2];
  assign o_fall = ~sr_q[1] &  sr_q[2];

endmodule

// File: rtl/spi_slave_mlf.sv
// SPI slave: oversampled SCLK/CS_n/MOSI, byte RX with DV pulse, byte TX on MISO.
module spi_slave_mlf
  import spi_mlf_pkg::*;
#(
  parameter int                    SPI_MODE     = 0,
  parameter logic [SPI_BYTE_W-1:0] IDLE_TX_BYTE = 8'h00
) (
  input logic            i_clk,
  input logic            i_rst_n,
  spi_slave_mlf_if.slave bus
);

  localparam logic CPOL = cpol(2'(SPI_MODE));
  localparam logic CPHA = cpha(2'(SPI_MODE));

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic lead, trail, sample, shift, load;
  logic [1:0] mosi_q;
  logic [SPI_BYTE_W-1:0] ld_byte;

  slv_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [SPI_BYTE_W-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic                  rx_dv_q, rx_dv_d;
  logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
  logic                  miso_q, miso_d;
  logic                  miso_en_q, miso_en_d;
  logic [SPI_BYTE_W-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.i_SPI_clk),
    .o_sync(sclk_sync), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.i_SPI_CS_n),
    .o_sync(cs_sync), .o_rise(cs_rise), .o_fall(cs_fall)
  );

  // MOSI only needs the plain 2-FF; it shares the SCLK synchroniser latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mosi_q <= '0;
    else          mosi_q <= {mosi_q[0], bus.i_SPI_MOSI};
  end

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead   = (sclk_rise | sclk_fall) & (sclk_sync != CPOL);
  assign trail  = (sclk_rise | sclk_fall) & (sclk_sync == CPOL);
  assign sample = CPHA ? trail : lead;
  assign shift  = CPHA ? lead  : trail;

  // Next state: framing, bit counting, shift registers and TX holding register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    miso_en_d  = ~cs_sync;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    load       = 1'b0;
    ld_byte    = hold_vld_q ? hold_q : IDLE_TX_BYTE;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_ACTIVE;
          load    = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          // Partial RX byte is dropped; pending TX byte stays in the holding reg.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (sample) begin
            rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], mosi_q[1]};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_byte_d = rx_sr_d;
              rx_dv_d   = 1'b1;
              if (CPHA) load = 1'b1;
            end
          end
          if (shift) begin
            if (CPHA) begin
              miso_d  = tx_sr_q[SPI_BYTE_W-1];
              tx_sr_d = tx_sr_q << 1;
            end else if (cnt_q == 3'd0) begin
              // 8th trailing edge after the wrap: byte boundary.
              load = 1'b1;
            end else begin
              miso_d  = tx_sr_q[SPI_BYTE_W-2];
              tx_sr_d = tx_sr_q << 1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      tx_sr_d    = ld_byte;
      cnt_d      = '0;
      hold_vld_d = 1'b0;
      if (!CPHA) miso_d = ld_byte[SPI_BYTE_W-1];
    end

    // Accept against the pre-load ready, so a same-cycle strobe feeds the next boundary.
    if (bus.i_TX_DV && !hold_vld_q) begin
      hold_d     = bus.i_TX_Byte;
      hold_vld_d = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      rx_byte_q  <= '0;
      rx_dv_q    <= 1'b0;
      tx_sr_q    <= '0;
      miso_q     <= 1'b0;
      miso_en_q  <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      tx_sr_q    <= tx_sr_d;
      miso_q     <= miso_d;
      miso_en_q  <= miso_en_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign bus.o_TX_Ready    = ~hold_vld_q;
  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_SPI_MISO    = miso_q;
  assign bus.o_SPI_MISO_En = miso_en_q;

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Bench: one slave per SPI mode, a behavioural master, RX scoreboard and TX model.
module tb_spi_slave_mlf;

  localparam int H = 6;  // SCLK half period in i_clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sclk, cs_n, tx_dv;
  logic       mosi;
  logic [7:0] tx_byte;
  wire  [3:0] tx_ready, rx_dv, miso, miso_en;
  wire  [7:0] rx_byte [4];

  int         n_chk = 0;
  int         n_fail = 0;
  int         act_m = 0;
  logic [7:0] rxq[$];
  logic [7:0] mq[$];
  logic       hv [4];
  logic [7:0] hb [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gm
    spi_slave_mlf_if sif ();
    assign sif.i_TX_Byte  = tx_byte;
    assign sif.i_TX_DV    = tx_dv[g];
    assign sif.i_SPI_clk  = sclk[g];
    assign sif.i_SPI_CS_n = cs_n[g];
    assign sif.i_SPI_MOSI = mosi;
    assign tx_ready[g]    = sif.o_TX_Ready;
    assign rx_dv[g]       = sif.o_RX_DV;
    assign rx_byte[g]     = sif.o_RX_Byte;
    assign miso[g]        = sif.o_SPI_MISO;
    assign miso_en[g]     = sif.o_SPI_MISO_En;
    spi_slave_mlf #(
      .SPI_MODE(g), .IDLE_TX_BYTE((g == 3) ? 8'hE7 : 8'h00)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(sif.slave)
    );
  end

  function automatic logic [7:0] idle_b(input int m);
    return (m == 3) ? 8'hE7 : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model of a byte load into the slave shift register.
  task automatic model_load(input int m, output logic [7:0] b);
    if (hv[m]) begin b = hb[m]; hv[m] = 1'b0; end
    else       b = idle_b(m);
  endtask

  task automatic tx_push(input int m, input logic [7:0] b);
    @(negedge clk);
    chk("tx_ready_pre", {31'd0, tx_ready[m]}, {31'd0, ~hv[m]});
    tx_byte  = b;
    tx_dv[m] = 1'b1;
    if (!hv[m]) begin hv[m] = 1'b1; hb[m] = b; end
    @(negedge clk);
    tx_dv[m] = 1'b0;
    chk("tx_ready_post", {31'd0, tx_ready[m]}, {31'd0, ~hv[m]});
  endtask

  // Master frame: CS low, nbits bits from mq, optional reset at the end, CS high.
  task automatic frame(input int m, input int nbits, input bit do_rst);
    logic       pol, pha;
    logic [7:0] mi, cur, b;
    pol   = m[1];
    pha   = m[0];
    act_m = m;
    mi    = '0;
    @(negedge clk);
    cs_n[m] = 1'b0;
    if (nbits > 0) mosi = mq[0][7];
    model_load(m, cur);
    repeat (8) @(negedge clk);
    chk("miso_en_on", {31'd0, miso_en[m]}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      b = mq[i/8];
      if (i % 8 == 7) rxq.push_back(b);
      if (!pha) begin
        mi = {mi[6:0], miso[m]};
        sclk[m] = ~pol;
        repeat (H) @(negedge clk);
        sclk[m] = pol;
        if (i + 1 < nbits) mosi = mq[(i+1)/8][7-((i+1)%8)];
        repeat (H) @(negedge clk);
      end else begin
        sclk[m] = ~pol;
        mosi = b[7-(i%8)];
        repeat (H) @(negedge clk);
        mi = {mi[6:0], miso[m]};
        sclk[m] = pol;
        repeat (H) @(negedge clk);
      end
      if (i % 8 == 7) begin
        chk("miso_byte", {24'd0, mi}, {24'd0, cur});
        model_load(m, cur);
      end
    end
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
      chk("rst_rx_dv",    {31'd0, rx_dv[m]},    32'd0);
      chk("rst_rx_byte",  {24'd0, rx_byte[m]},  32'd0);
      chk("rst_miso",     {31'd0, miso[m]},     32'd0);
      chk("rst_miso_en",  {31'd0, miso_en[m]},  32'd0);
      for (int k = 0; k < 4; k++) hv[k] = 1'b0;
    end
    repeat (H) @(negedge clk);
    cs_n[m] = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    chk("miso_en_off", {31'd0, miso_en[m]}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Scoreboard monitor: every RX_DV pulse must match the oldest expected byte.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m] === 1'b1) begin
        if (m != act_m || rxq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_unexpected: mode %0d got %0h expected no pulse", m, rx_byte[m]);
        end else begin
          chk("rx_byte", {24'd0, rx_byte[m]}, {24'd0, rxq.pop_front()});
        end
      end
    end
  end

  initial begin
    int m, nb;
    rst_n   = 1'b0;
    cs_n    = 4'hF;
    sclk    = 4'b1100;
    tx_dv   = '0;
    tx_byte = '0;
    mosi    = 1'b0;
    for (int k = 0; k < 4; k++) begin hv[k] = 1'b0; hb[k] = '0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("init_tx_ready", {31'd0, tx_ready[k]}, 32'd1);
      chk("init_rx_dv",    {31'd0, rx_dv[k]},    32'd0);
      chk("init_rx_byte",  {24'd0, rx_byte[k]},  32'd0);
      chk("init_miso",     {31'd0, miso[k]},     32'd0);
      chk("init_miso_en",  {31'd0, miso_en[k]},  32'd0);
    end

    // Mode 0 loopback
    tx_push(0, 8'h3C);
    mq = '{8'h9A};
    frame(0, 8, 1'b0);

    // Continuous two bytes, nothing pending
    mq = '{8'h99, 8'h77};
    frame(0, 16, 1'b0);

    // Modes 1..3
    for (int k = 1; k < 4; k++) begin
      tx_push(k, 8'h5A);
      mq = '{8'hA5};
      frame(k, 8, 1'b0);
    end

    // CS_n abort after 5 bits in every mode, then a full byte
    for (int k = 0; k < 4; k++) begin
      mq = '{8'($urandom)};
      frame(k, 5, 1'b0);
      mq = '{8'hC3};
      frame(k, 8, 1'b0);
    end

    // TX handshake: second strobe while not ready is ignored
    tx_push(0, 8'h11);
    tx_push(0, 8'h22);
    mq = '{8'($urandom)};
    frame(0, 8, 1'b0);
    mq = '{8'($urandom)};
    frame(0, 8, 1'b0);

    // Pending byte survives an abort that occurs after it was loaded? It is consumed
    // at CS fall; a byte pushed mid-idle after the abort is used by the next frame.
    tx_push(2, 8'h6D);
    mq = '{8'($urandom)};
    frame(2, 3, 1'b0);
    tx_push(2, 8'hB4);
    mq = '{8'($urandom)};
    frame(2, 8, 1'b0);

    // Reset mid-byte, then a clean byte
    tx_push(0, 8'h44);
    mq = '{8'($urandom)};
    frame(0, 3, 1'b1);
    mq = '{8'hF0};
    frame(0, 8, 1'b0);

    // Random frames across all modes
    for (int r = 0; r < 12; r++) begin
      m  = int'($urandom_range(0, 3));
      nb = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) tx_push(m, 8'($urandom));
      mq = {};
      for (int j = 0; j < nb; j++) mq.push_back(8'($urandom));
      frame(m, 8 * nb, 1'b0);
    end

    repeat (10) @(negedge clk);
    chk("rxq_drained", rxq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_slave_mlf.md
# spi_slave_mlf

SPI slave (responder) that terminates the link driven by the team's SPI master. It oversamples SCLK, MOSI and CS_n in the local `i_clk` domain and deserialises one byte per 8 sampling edges. It serialises a user-supplied byte onto MISO in the same transfer. All four SPI modes are selectable at build time, and the user side uses the same one-cycle DV byte handshake as the master.

## Interface
- `SPI_MODE`, default 0: 0..3. CPOL = `SPI_MODE[1]`, CPHA = `SPI_MODE[0]`.
- `IDLE_TX_BYTE`, default 8'h00: byte shifted out when no TX byte is pending at a byte boundary.
- `i_clk` in 1: system clock. All logic is on its rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_TX_Byte` in 8: byte to transmit on MISO.
- `i_TX_DV` in 1: one-cycle strobe. Captures `i_TX_Byte` when `o_TX_Ready`=1.
- `o_TX_Ready` out 1: 1 while the TX holding register is empty.
- `o_RX_DV` out 1: one-cycle pulse when a full byte has been received.
- `o_RX_Byte` out 8: last received byte. Valid from the `o_RX_DV` cycle and held until the next pulse.
- `i_SPI_clk` in 1: SCLK from the master. Asynchronous.
- `i_SPI_CS_n` in 1: chip select, active-low. Asynchronous.
- `i_SPI_MOSI` in 1: data from the master. Asynchronous.
- `o_SPI_MISO` out 1: data to the master.
- `o_SPI_MISO_En` out 1: MISO output enable. The top level tristates MISO when this is 0.

## Operation
- **Synchronisation:** SCLK, CS_n and MOSI each pass through a 2-FF synchroniser. A third stage on SCLK and CS_n gives the previous value for edge detection.
- **Edge types:**
  - Leading edge = transition away from CPOL.
  - Trailing edge = transition back to CPOL.
  - Sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. The other edge is the shift edge.
- **States:**
  - IDLE: CS_n is high.
  - ACTIVE: CS_n is low.
  - IDLE -> ACTIVE on a synchronised CS_n fall.
  - ACTIVE -> IDLE on a synchronised CS_n rise, from any point in the byte.
- **Byte load:** on entering ACTIVE, and at every byte boundary:
  - the TX shift register loads the pending byte (if any), which clears the holding register so `o_TX_Ready` returns to 1; otherwise it loads `IDLE_TX_BYTE`;
  - the 3-bit bit counter is set to 0.
- **Sample edge:** shift the synchronised MOSI into the RX shift register (MSB first) and increment the bit counter. On the 8th sample:
  - the counter wraps to 0;
  - `o_RX_Byte` <= assembled byte;
  - `o_RX_DV` pulses for 1 cycle.
- **CPHA=0 MISO:**
  - The MSB is driven on entering ACTIVE.
  - Trailing edges 1..7 advance to the next bit.
  - The 8th trailing edge is the byte boundary: load the next byte and drive its MSB.
- **CPHA=1 MISO:**
  - Each leading edge drives the next bit, starting with the MSB.
  - The byte boundary is the 8th sample (trailing edge).
- **TX holding register:** accepts `i_TX_DV` only when `o_TX_Ready`=1. `i_TX_DV` while not ready is ignored and the register keeps its first byte.
- **Simultaneous events:** `i_TX_DV` in the same cycle as a byte-boundary load is captured into the holding register and used at the following boundary. The current load uses the previous pending byte or `IDLE_TX_BYTE`.
- **CS_n rise mid-byte:**
  - the partial RX byte is discarded, with no `o_RX_DV`;
  - the bit counter clears;
  - any byte still held in the holding register (not yet loaded into the shift register) is retained;
  - `o_SPI_MISO_En` drops.
- **Reset values:** `o_TX_Ready`=1, `o_RX_DV`=0, `o_RX_Byte`=8'h00, `o_SPI_MISO`=0, `o_SPI_MISO_En`=0. State = IDLE, counter = 0, holding register empty. Async reset applies mid-transfer too.

## Timing
- **Input constraint:** SCLK half-period ≥ 4 `i_clk` cycles. The master is therefore configured with CLKS_PER_HALF_BIT ≥ 4. CS_n must fall ≥ 4 `i_clk` cycles before the first SCLK edge.
- **Sample latency:** `o_RX_DV` rises 3 `i_clk` cycles after the 8th sampling SCLK edge at the pin (2 synchroniser + 1 register).
- **MISO latency:** `o_SPI_MISO` updates 3 `i_clk` cycles after the shift edge at the pin. It is stable before the master's next sample edge under the constraint above.
- **Output enable:** `o_SPI_MISO_En` follows synchronised CS_n with 3-cycle latency.
- **Back-to-back bytes:** with CS_n held low, transfers are seamless. There is no idle bit between bytes.

## Structure
- **Package `spi_mlf_pkg`:**
  - mode decode functions (`cpol(mode)`, `cpha(mode)`);
  - slave state encoding (IDLE, ACTIVE);
  - the shared `SPI_BYTE_W`=8 constant, reused by the master.
- **Sub-module `spi_sync_edge`:** 2-FF synchroniser plus edge detector, producing sync, rise and fall. Instantiated for SCLK and CS_n. MOSI uses a plain 2-FF synchroniser.

## Test plan
- **Mode 0 loopback:** master TX 8'h9A, slave TX preloaded 8'h3C, CS_n framing the byte. Slave `o_RX_Byte`=8'h9A with one `o_RX_DV` pulse; master receives 8'h3C.
- **Continuous transfer:** CS_n held low over 8'h99 then 8'h77 with no slave byte pending. Two `o_RX_DV` pulses (8'h99, 8'h77); master receives 8'h00, 8'h00.
- **Modes 1/2/3:** repeat 8'hA5 <-> 8'h5A in each mode. Exact match in both directions for every mode.
- **CS_n abort:** CS_n rises after 5 bits, then a full byte 8'hC3 follows. No `o_RX_DV` for the aborted byte; the next `o_RX_Byte`=8'hC3.
- **TX handshake:** `i_TX_DV` with 8'h11, then `i_TX_DV` with 8'h22 while `o_TX_Ready`=0. The master receives 8'h11; the 8'h22 strobe is ignored.
- **Reset mid-byte:** assert `i_rst_n`=0 after 3 bits. All outputs take their reset values immediately; the next full byte 8'hF0 is received correctly.
